// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan controller for a DIGITS-wide common-anode
//   7-segment display. Each digit is driven for PRESCALE_MAX+1 clocks, and
//   all anodes are off for BLANK_CYCLES clocks before every digit so that
//   segment data never ghosts onto the next anode. New data is captured
//   through load/load_ack into a pending buffer. It moves into the shadow
//   register only at a frame boundary, so a displayed frame never mixes
//   old and new data.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, leading-zero digits (i>0 with all nibbles i..DIGITS-1
//     equal to zero) show no segments, but their anode and dp still follow
//     the scan.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      scan enable; low parks the scanner in IDLE (dark)
//   load        capture request for data_in / dp_in
//   data_in     4*DIGITS hex nibbles, nibble i drives digit i
//   dp_in       decimal point per digit, 1 = lit
//   load_ack    one-cycle pulse after a capture
//   anode_n     active-low digit select
//   seg_n       active-low segments {g,f,e,d,c,b,a}
//   dp_n        active-low decimal point
//   frame_done  one-cycle pulse after the last digit of a frame
module display_scan_controller #(
  parameter int          DIGITS       = 4,
  parameter logic [15:0] PRESCALE_MAX = 16'd49999,
  parameter int          BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Active-low hex decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [15:0]       pre, pre_nxt;
  logic [BLK_W-1:0]  blk, blk_nxt;
  logic              frame_nxt;

  logic [4*DIGITS-1:0] pending_data;
  logic [DIGITS-1:0]   pending_dp;
  logic                pending_valid;
  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic                commit;

  logic [DIGITS-1:0]   blank_mask;

  // Values computed for the output register stage.
  logic [DIGITS-1:0]   anode_p0;
  logic [6:0]          seg_p0;
  logic                dp_p0;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                lz_sel;

  // Scan sequencing: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      pre   <= '0;
      blk   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      pre   <= pre_nxt;
      blk   <= blk_nxt;
    end
  end

  // Scan sequencing: next-state logic. enable low overrides everything and
  // clears the counters so a re-enable always restarts at digit 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pre_nxt   = pre;
    blk_nxt   = blk;
    frame_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      pre_nxt   = '0;
      blk_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          blk_nxt   = '0;
          pre_nxt   = '0;
        end
        BLANK: begin
          if (blk == BLK_LAST) begin
            state_nxt = DRIVE;
            blk_nxt   = '0;
            pre_nxt   = '0;
          end else begin
            blk_nxt = blk + 1'b1;
          end
        end
        DRIVE: begin
          if (pre == PRESCALE_MAX) begin
            state_nxt = BLANK;
            blk_nxt   = '0;
            pre_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              frame_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          pre_nxt   = '0;
          blk_nxt   = '0;
        end
      endcase
    end
  end

  // Shadow takes the pending value as it stood before this edge, so a load
  // landing on the frame boundary waits for the following frame.
  assign commit = frame_nxt && pending_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_data  <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow_data   <= '0;
      shadow_dp     <= '0;
    end else begin
      if (commit) begin
        shadow_data <= pending_data;
        shadow_dp   <= pending_dp;
      end
      if (load) begin
        pending_data  <= data_in;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end else if (commit) begin
        pending_valid <= 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Bit i set when digit i>0 and every nibble from i upward is zero.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run  = run && (d[4*i +: 4] == 4'h0);
      m[i] = run;
    end
    return m;
  endfunction

  // Mask tracks shadow; the reset value is the mask of an all-zero shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (commit) begin
      blank_mask <= lz_mask(pending_data);
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Select the digit that will be on the anodes after this edge.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nib_sel = shadow_data[4*i +: 4];
        dp_sel  = shadow_dp[i];
        lz_sel  = blank_mask[i];
      end
    end
  end

  always_comb begin
    anode_p0 = ANODE_OFF;
    seg_p0   = SEG_OFF;
    dp_p0    = 1'b1;
    if (state_nxt == DRIVE) begin
      anode_p0 = ANODE_OFF ^ (DIGITS'(1) << idx_nxt);
      seg_p0   = lz_sel ? SEG_OFF : hex_decode(nib_sel);
      dp_p0    = ~dp_sel;
    end
  end

  // Output register stage: pins always reflect the registered scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n    <= ANODE_OFF;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      anode_n    <= anode_p0;
      seg_n      <= seg_p0;
      dp_n       <= dp_p0;
      load_ack   <= load;
      frame_done <= frame_nxt;
    end
  end

endmodule
